md_unit_seq: RTL and testbench
==============================

// Module: md_unit_seq
// PURPOSE
//  Multiply/divide sequencer for the E stage of the pipelined MIPS core, beside the ALU.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the HI/LO registers.
//  Models fixed-latency mult/div with a busy counter.
//  Drives the D-stage stall for any instruction that touches HI/LO while the unit is busy.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
//  CNT_W        4   counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
// PORTS
//  clk     in   1   clock, rising edge
//  reset   in   1   asynchronous, active-high reset
//  start   in   1   E-stage md instruction valid this cycle
//  mdop    in   3   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (no-op)
//  flush   in   1   exception/flush in E this cycle; suppresses start
//  rs_val  in   32  operand A / MTHI, MTLO source
//  rt_val  in   32  operand B
//  md_use  in   1   D-stage instruction is mult/div/mf/mt
//  busy    out  1   unit computing; registered
//  hi      out  32  HI register
//  lo      out  32  LO register
//  stall   out  1   combinational: md_use & (busy | go_md), go_md defined below
// BEHAVIOUR
//  - Reset (async): busy=0, counter=0, hi=0, lo=0, pending result=0, state=IDLE.
//    A reset mid-operation discards the pending result.
//  - go = start & ~flush & ~busy.
//    A start while busy is ignored; the stall logic makes this case illegal upstream.
//    go_md = go & mdop in {1..4}.
//  - States:
//    - IDLE: on go_md, latch the 64-bit result into pending, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
//    - RUN: busy=1, counter decrements each cycle. At the edge where counter==1: {hi,lo} <= pending, busy->0, go to IDLE.
//  - Latency: busy is high for exactly N cycles after the issue edge (N = MULT_CYCLES or DIV_CYCLES).
//    hi/lo are visible in the first cycle with busy=0.
//  - MTHI/MTLO with go: hi or lo <= rs_val at the next edge. No busy, no state change.
//  - Arithmetic:
//    - MULT: {hi,lo} = $signed(rs)*$signed(rt), full 64 bits.
//    - MULTU: {hi,lo} = unsigned 64-bit product.
//    - DIV: lo = quotient truncated toward zero; hi = remainder, sign follows the dividend.
//    - DIVU: unsigned quotient and remainder.
//  - Divide by zero: see CONFIGURATION.
//  - Flush during RUN does not cancel; the issued op already passed the exception point.
//  - mdop 0 or 7 with go: no effect.
//  - Reads of hi/lo while busy return the old values; the stall prevents such reads.
// CONFIGURATION
//  MD_DIV0_HOLD_EN defined:
//    DIV/DIVU with rt_val==0 still runs DIV_CYCLES busy cycles.
//    hi/lo keep their prior values at completion.
//  Not defined:
//    divide-by-zero completes normally with hi=rs_val, lo=32'hFFFF_FFFF (both DIV and DIVU).
// TESTING
//  - MULT rs=0xFFFFFFFD, rt=5 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  - DIVU 7/2 -> busy for 10 cycles, then lo=3, hi=1.
//    DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  - MTHI rs=0x1234 -> hi=0x1234 next cycle, busy stays 0.
//    MTLO during busy is ignored (lo unchanged).
//  - start=1 with flush=1, mdop=MULT -> busy stays 0, hi/lo unchanged, stall=0.
//  - md_use=1 on the issue cycle and while busy -> stall=1.
//    Stall drops in the first cycle after busy falls.
//  - reset pulse mid-DIV (cycle 4) -> busy=0, hi=lo=0 immediately, no later writeback.
//    DIV 9/0 -> hi/lo per MD_DIV0_HOLD_EN (run both builds).

Source files
------------

// File: rtl/md_unit_seq.sv
// Multiply/divide sequencer owning HI/LO, with a fixed-latency busy counter and D-stage stall.
// Optional MD_DIV0_HOLD_EN: divide-by-zero keeps the prior HI/LO instead of writing {rs, all-ones}.
module md_unit_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic        flush,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      pend_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             wb_en;

    logic        go;
    logic        go_md;
    logic        is_div;
    logic        div0;
    logic [63:0] smul;
    logic [63:0] umul;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] dq;
    logic [31:0] dr;
    logic [63:0] res;

    assign go     = start & ~flush & ~busy_q;
    assign go_md  = go & (mdop >= 3'd1) & (mdop <= 3'd4);
    assign is_div = (mdop == 3'd3) | (mdop == 3'd4);
    assign div0   = (rt_val == 32'd0);
    assign stall  = md_use & (busy_q | go_md);

    assign smul = $signed({{32{rs_val[31]}}, rs_val}) *
                  $signed({{32{rt_val[31]}}, rt_val});
    assign umul = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide on magnitudes: quotient truncates toward zero, remainder takes dividend sign
    assign a_neg = (mdop == 3'd3) & rs_val[31];
    assign b_neg = (mdop == 3'd3) & rt_val[31];
    assign ua    = a_neg ? (~rs_val + 32'd1) : rs_val;
    assign ub    = b_neg ? (~rt_val + 32'd1) : rt_val;
    assign uq    = div0 ? 32'd0 : ua / ub;
    assign ur    = div0 ? 32'd0 : ua % ub;
    assign sq    = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    assign sr    = a_neg ? (~ur + 32'd1) : ur;
    assign dq    = div0 ? 32'hFFFF_FFFF : sq;
    assign dr    = div0 ? rs_val : sr;

    always_comb begin
        res = 64'd0;
        unique case (mdop)
            3'd1:    res = smul;
            3'd2:    res = umul;
            3'd3,
            3'd4:    res = {dr, dq};
            default: res = 64'd0;
        endcase
    end

`ifdef MD_DIV0_HOLD_EN
    logic hold_q;
    assign wb_en = ~hold_q;
`else
    assign wb_en = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef MD_DIV0_HOLD_EN
            hold_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (go_md) begin
                        pend_q  <= res;
                        cnt_q   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef MD_DIV0_HOLD_EN
                        hold_q  <= is_div & div0;
`endif
                    end else if (go && mdop == 3'd5) begin
                        hi_q <= rs_val;
                    end else if (go && mdop == 3'd6) begin
                        lo_q <= rs_val;
                    end
                end
                RUN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        if (wb_en) begin
                            hi_q <= pend_q[63:32];
                            lo_q <= pend_q[31:0];
                        end
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_seq.sv
// Bench for md_unit_seq: directed vector table, corner sequences and randomized ops vs a reference model.
module tb_md_unit_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic        flush;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdop   (mdop),
        .flush  (flush),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .md_use (md_use),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit integer arithmetic on the architectural rules
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin p = sa * sb; {m_hi, m_lo} = p; end
            3'd2: begin p = ua * ub; {m_hi, m_lo} = p; end
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
`ifndef MD_DIV0_HOLD_EN
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
`endif
                end else if (op == 3'd3) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    m_lo = sq[31:0];
                    m_hi = sr[31:0];
                end else begin
                    m_lo = 32'(ua / ub);
                    m_hi = 32'(ua % ub);
                end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int lat(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 5;
        if (op == 3'd3 || op == 3'd4) return 10;
        return 0;
    endfunction

    // Issue one op with md_use held, count busy cycles, check stall throughout
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int ncyc);
        @(negedge clk);
        start = 1'b1; mdop = op; rs_val = a; rt_val = b; md_use = 1'b1;
        #1;
        chk("stall_issue", {63'd0, stall}, {63'd0, lat(op) != 0});
        @(negedge clk);
        start = 1'b0; mdop = 3'd0;
        ncyc = 0;
        while (busy === 1'b1 && ncyc < 40) begin
            if (stall !== 1'b1) chk("stall_busy", {63'd0, stall}, 64'd1);
            ncyc++;
            @(negedge clk);
        end
        chk("stall_drop", {63'd0, stall}, 64'd0);
        md_use = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ecyc;
    } vec_t;

    vec_t vt[6];

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; mdop = 3'd0; flush = 1'b0;
        rs_val = 32'd0; rt_val = 32'd0; md_use = 1'b0;

        vt[0] = '{3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
        vt[1] = '{3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10};
        vt[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vt[3] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vt[4] = '{3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10};
        vt[5] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10};

        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vt[i]) begin
            issue(vt[i].op, vt[i].a, vt[i].b, n);
            chk($sformatf("vec%0d_cyc", i), 64'(n), 64'(vt[i].ecyc));
            chk($sformatf("vec%0d_hilo", i), {hi, lo}, {vt[i].ehi, vt[i].elo});
        end
        m_hi = hi; m_lo = lo;

        // MTHI: visible next cycle, never busy
        @(negedge clk);
        start = 1'b1; mdop = 3'd5; rs_val = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        m_hi = 32'h1234;

        // MTLO while busy is ignored
        @(negedge clk);
        start = 1'b1; mdop = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
        @(negedge clk);
        mdop = 3'd6; rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; mdop = 3'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
        chk("mtlo_busy_lo", {hi, lo}, {32'd0, 32'd12});
        m_hi = 32'd0; m_lo = 32'd12;

        // Flushed start does nothing
        @(negedge clk);
        start = 1'b1; flush = 1'b1; mdop = 3'd1; rs_val = 32'd9;
        rt_val = 32'd9; md_use = 1'b1;
        #1;
        chk("flush_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0; md_use = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hilo", {hi, lo}, {m_hi, m_lo});

        // Reset in the 4th busy cycle of a DIV discards the result
        @(negedge clk);
        start = 1'b1; mdop = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_busy_pre", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_busy", {63'd0, busy}, 64'd0);
        chk("rstmid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rstmid_nowb", {hi, lo}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // Prime nonzero HI/LO then divide by zero
        issue(3'd2, 32'd6, 32'd7, n);
        model(3'd2, 32'd6, 32'd7);
        issue(3'd3, 32'd9, 32'd0, n);
        model(3'd3, 32'd9, 32'd0);
        chk("div0_cyc", 64'(n), 64'd10);
`ifdef MD_DIV0_HOLD_EN
        chk("div0_hilo", {hi, lo}, {32'd0, 32'd42});
`else
        chk("div0_hilo", {hi, lo}, {32'd9, 32'hFFFF_FFFF});
`endif
        issue(3'd4, 32'hFFFF_FFF0, 32'd0, n);
        model(3'd4, 32'hFFFF_FFF0, 32'd0);
        chk("div0u_hilo", {hi, lo}, {m_hi, m_lo});

        // Randomized ops against the model
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            issue(op, a, b, n);
            model(op, a, b);
            chk($sformatf("rnd%0d_cyc", k), 64'(n), 64'(lat(op)));
            chk($sformatf("rnd%0d_hilo", k), {hi, lo}, {m_hi, m_lo});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
